bus_arbiter: RTL and testbench

Round-robin arbiter for the shared system bus, four masters. Each master's bus interface raises an active-low request and waits for its active-low grant before driving address strobe, address and data. The arbiter sits between those bus interfaces and the bus multiplexer. It holds a grant until the owner withdraws its request, and exposes the current owner index so the master-side mux can be steered.

---
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_bus_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Purpose  : Four-master round-robin arbiter for the shared system bus.
//            Active-low requests in, registered active-low grants and owner
//            index out. A grant is held until its owner withdraws the request.
//            Optional hold-limit timeout, enabled by defining the macro
//            BUS_ARB_TIMEOUT_EN (MAX_HOLD sets the limit in granted cycles).
// Revision : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_,
  output logic [3:0] grnt_,
  output logic [1:0] owner,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] last_q;
  logic [1:0] last_d;
  logic [1:0] owner_d;
  logic [3:0] grnt_d;
  logic [1:0] winner;
  logic [1:0] scan_idx;
  logic       scan_found;
  logic       any_req;
  logic       new_grant;
  logic       timeout_d;
  logic       hold_expired;

  assign any_req = ~&req_;

  // Round-robin winner: first requester in order last+1, last+2, last+3, last.
  always_comb begin
    winner     = last_q;
    scan_found = 1'b0;
    scan_idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_q + 2'(i);
      if (!scan_found && !req_[scan_idx]) begin
        winner     = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  // Next-state and next-output decode; the current owner is never pre-empted.
  always_comb begin
    state_d   = state_q;
    grnt_d    = grnt_;
    owner_d   = owner;
    last_d    = last_q;
    timeout_d = 1'b0;
    new_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d   = GRANT;
          grnt_d    = ~(4'b0001 << winner);
          owner_d   = winner;
          last_d    = winner;
          new_grant = 1'b1;
        end
      end
      GRANT: begin
        if (!req_[owner]) begin
          // Owner still wants the bus: keep it unless the hold limit fires.
          if (hold_expired) begin
            state_d   = IDLE;
            grnt_d    = 4'b1111;
            last_d    = owner;
            timeout_d = 1'b1;
          end
        end else if (any_req) begin
          // Direct handover; last equals the old owner here, so the search
          // starts just after it.
          grnt_d    = ~(4'b0001 << winner);
          owner_d   = winner;
          last_d    = winner;
          new_grant = 1'b1;
        end else begin
          state_d = IDLE;
          grnt_d  = 4'b1111;
        end
      end
      default: begin
        state_d = IDLE;
        grnt_d  = 4'b1111;
      end
    endcase
  end

  // State, grant, owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grnt_   <= 4'b1111;
      owner   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grnt_   <= grnt_d;
      owner   <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       timeout_q;

  // hold_q counts completed granted cycles, so the current cycle is the
  // (hold_q+1)-th; the grant is revoked at the end of cycle MAX_HOLD.
  assign hold_expired = (({1'b0, hold_q} + 9'd1) == 9'(MAX_HOLD));
  assign timeout      = timeout_q;

  // Hold counter clears on each new grant and advances every granted cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
      if (new_grant) begin
        hold_q <= 8'd0;
      end else if (state_q == GRANT) begin
        hold_q <= hold_q + 8'd1;
      end
    end
  end
`else
  logic unused_cfg;

  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
  assign unused_cfg   = ^{new_grant, timeout_d, 8'(MAX_HOLD)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Purpose  : Directed self-checking bench for bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_;
  logic [3:0] grnt_;
  logic [1:0] owner;
  logic       timeout;

  int vectors;
  int miscompares;

  bus_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_    (req_),
    .grnt_   (grnt_),
    .owner   (owner),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                     input logic et);
    vectors++;
    assert (grnt_ === eg) else begin
      miscompares++;
      $error("FAIL %s grnt_: observed %b expected %b", tag, grnt_, eg);
    end
    vectors++;
    assert (owner === eo) else begin
      miscompares++;
      $error("FAIL %s owner: observed %0d expected %0d", tag, owner, eo);
    end
    vectors++;
    assert (timeout === et) else begin
      miscompares++;
      $error("FAIL %s timeout: observed %b expected %b", tag, timeout, et);
    end
  endtask

  initial begin
    int m;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    req_  = 4'b1111;
    step();
    step();
    chk("reset", 4'b1111, 2'd0, 1'b0);
    reset = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle", 4'b1111, 2'd0, 1'b0);
    end

    // Single requester master 2, hold 5 cycles, release
    req_ = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("m2_hold", 4'b1011, 2'd2, 1'b0);
    end
    req_ = 4'b1111;
    step();
    chk("m2_release", 4'b1111, 2'd2, 1'b0);

    // All masters request after reset: 0,1,2,3,0 with direct handovers
    reset = 1'b1;
    step();
    chk("reset2", 4'b1111, 2'd0, 1'b0);
    reset = 1'b0;
    req_  = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      m = g % 4;
      for (int c = 0; c < 3; c++) begin
        step();
        chk("rr_seq", ~(4'b0001 << m), 2'(m), 1'b0);
        if (c == 0 && g > 0) req_[(m + 3) % 4] = 1'b0;
        if (c == 2) req_[m] = 1'b1;
      end
    end
    req_ = 4'b1111;
    step();
    chk("rr_idle", 4'b1111, 2'd0, 1'b0);

    // Master 1 owns, masters 3 and 0 wait; handover goes to 3
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_  = 4'b1101;
    step();
    chk("m1_grant", 4'b1101, 2'd1, 1'b0);
    req_ = 4'b0100;
    step();
    chk("m1_no_preempt", 4'b1101, 2'd1, 1'b0);
    req_ = 4'b0110;
    step();
    chk("handover_m3", 4'b0111, 2'd3, 1'b0);
    req_ = 4'b1111;
    step();
    chk("m3_release", 4'b1111, 2'd3, 1'b0);

    // Reset while master 2 holds, then 0 beats 2
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_  = 4'b1011;
    step();
    chk("m2_grant", 4'b1011, 2'd2, 1'b0);
    reset = 1'b1;
    step();
    chk("reset_mid", 4'b1111, 2'd0, 1'b0);
    step();
    chk("reset_hold", 4'b1111, 2'd0, 1'b0);
    reset = 1'b0;
    req_  = 4'b1010;
    step();
    chk("post_reset_m0", 4'b1110, 2'd0, 1'b0);
    req_ = 4'b1111;
    step();
    chk("post_reset_idle", 4'b1111, 2'd0, 1'b0);

    // Master 0 holds continuously
    reset = 1'b1;
    step();
    reset = 1'b0;
    req_  = 4'b1110;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_hold", 4'b1110, 2'd0, 1'b0);
    end
    step();
    chk("to_revoke", 4'b1111, 2'd0, 1'b1);
    step();
    chk("to_regrant", 4'b1110, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("to_hold2", 4'b1110, 2'd0, 1'b0);
    end
    req_ = 4'b1111;
    step();
    chk("to_release_at_limit", 4'b1111, 2'd0, 1'b0);
`else
    for (int i = 0; i < 12; i++) begin
      step();
      chk("hold_forever", 4'b1110, 2'd0, 1'b0);
    end
    req_ = 4'b1111;
    step();
    chk("hold_release", 4'b1111, 2'd0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
